// File: rtl/negedge_rx_skid_if.sv
// Valid/ready handshake bundle between the negedge launch stage, the posedge
// receive skid buffer and the downstream divider pipeline stage.
interface negedge_rx_skid_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic [WIDTH-1:0] In;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] Out;
    logic             out_ready;

    // Producer/consumer side (drives words in, accepts words out)
    modport master (
        output in_valid,
        output In,
        input  in_ready,
        input  out_valid,
        input  Out,
        output out_ready
    );

    // Buffer side
    modport slave (
        input  in_valid,
        input  In,
        output in_ready,
        output out_valid,
        output Out,
        input  out_ready
    );
endinterface

// File: rtl/negedge_rx_skid.sv
// Posedge receive stage: captures words launched on the negedge into a
// 2-entry head/skid buffer and forwards them in order over valid/ready.
module negedge_rx_skid #(
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    negedge_rx_skid_if.slave       bus,
    output logic [1:0]             count,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_next;
    logic             overflow_reg;
    logic             overflow_next;

    logic             in_ready_int;
    logic             out_valid_int;
    logic             push;
    logic             pop;

    assign push = bus.in_valid & in_ready_int;
    assign pop  = out_valid_int & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush wins over any push or pop
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: if (push) state_next = ONE;
                ONE: begin
                    if (push && !pop)      state_next = FULL;
                    else if (pop && !push) state_next = EMPTY;
                end
                FULL:  if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Data path: head always holds the oldest word, skid the younger one
    always_comb begin
        head_next = head_reg;
        skid_next = skid_reg;
        if (!flush) begin
            unique case (state_reg)
                EMPTY: if (push) head_next = bus.In;
                ONE: begin
                    if (push && pop)  head_next = bus.In;
                    else if (push)    skid_next = bus.In;
                end
                FULL:  if (pop) head_next = skid_reg;
                default: ;
            endcase
        end
    end

    // An offered word while full is dropped and remembered until flush/reset
    always_comb begin
        overflow_next = overflow_reg;
        if (flush) begin
            overflow_next = 1'b0;
        end else if (bus.in_valid && !in_ready_int) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            skid_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            skid_reg     <= skid_next;
            overflow_reg <= overflow_next;
        end
    end

    // Outputs decoded from state only; Out is gated so stale data never leaks
    always_comb begin
        in_ready_int  = 1'b1;
        out_valid_int = 1'b0;
        count         = 2'd0;
        unique case (state_reg)
            EMPTY: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
                count         = 2'd0;
            end
            ONE: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b1;
                count         = 2'd1;
            end
            FULL: begin
                in_ready_int  = 1'b0;
                out_valid_int = 1'b1;
                count         = 2'd2;
            end
            default: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
                count         = 2'd0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.Out       = out_valid_int ? head_reg : '0;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_negedge_rx_skid.sv
// Randomized bench for negedge_rx_skid: a queue-based model of the buffer is
// compared on every falling edge, plus directed scenarios with literal checks.
module tb_negedge_rx_skid;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] count;
    logic       overflow;

    negedge_rx_skid_if #(.WIDTH(2)) bus ();

    negedge_rx_skid #(.WIDTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: words held in arrival order, plus sticky overflow
    logic [1:0] mq[$];
    logic       m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit do_push = bus.in_valid && (mq.size() < 2);
            automatic bit do_pop  = bus.out_ready && (mq.size() > 0);
            if (bus.in_valid && mq.size() == 2) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(bus.In);
        end
    end

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
        chk("m_out", {30'd0, bus.Out}, (mq.size() > 0) ? {30'd0, mq[0]} : 32'd0);
        chk("m_count", {30'd0, count}, mq.size());
        chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
        chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end

    // Apply inputs, then advance past the capturing edge
    task automatic drive(input logic v, input logic [1:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.In        = d;
        bus.out_ready = r;
        flush         = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a word offered
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b1;
        bus.In        = 2'b11;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out", {30'd0, bus.Out}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_out", {30'd0, bus.Out}, 32'd3);
        chk("rel_out_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);

        // Streaming with out_ready held high
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        chk("strm_out0", {30'd0, bus.Out}, 32'd1);
        drive(1'b1, 2'b10, 1'b1, 1'b0);
        chk("strm_out1", {30'd0, bus.Out}, 32'd2);
        drive(1'b1, 2'b11, 1'b1, 1'b0);
        chk("strm_out2", {30'd0, bus.Out}, 32'd3);
        chk("strm_count", {30'd0, count}, 32'd1);
        drive(1'b1, 2'b00, 1'b1, 1'b0);
        chk("strm_out3", {30'd0, bus.Out}, 32'd0);
        chk("strm_valid3", {31'd0, bus.out_valid}, 32'd1);
        chk("strm_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);

        // Stall fills the buffer, then drains in order
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("stall_count", {30'd0, count}, 32'd2);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_head", {30'd0, bus.Out}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_out1", {30'd0, bus.Out}, 32'd2);
        chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

        // Overflow while full; the dropped word never appears; flush clears
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {30'd0, count}, 32'd2);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_next", {30'd0, bus.Out}, 32'd2);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("flush_ovf", {31'd0, overflow}, 32'd0);
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_out", {30'd0, bus.Out}, 32'd0);

        // Simultaneous push and pop in ONE
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("pp_head", {30'd0, bus.Out}, 32'd2);
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        chk("pp_count", {30'd0, count}, 32'd1);
        chk("pp_out", {30'd0, bus.Out}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while full
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_count", {30'd0, count}, 32'd0);
        chk("arst_out", {30'd0, bus.Out}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < 3));
        end

        drive(1'b0, 2'b00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/negedge_rx_skid.md
# negedge_rx_skid

Posedge receive stage for 2-bit control/data words launched by the divider's negedge buffer stages. It captures each word on the rising clock edge and holds it in a 2-entry skid buffer. It hands the words downstream over a valid/ready handshake, so a stalled consumer never drops or duplicates a word. It sits between a negedge launch register and the next posedge divider pipeline stage (quotient-bit/control collection).

## Interface
- WIDTH, 2, data word width in bits (legal range 1..32)
- clk  input  1  clock; every register updates on the rising edge only
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear; discards all held words
- in_valid  input  1  upstream word In is valid this cycle
- In  input  WIDTH  upstream data, stable around the rising edge because it is launched on the negedge
- in_ready  output  1  buffer can accept a word this cycle
- out_valid  output  1  Out holds a valid word
- Out  output  WIDTH  head-of-buffer word
- out_ready  input  1  downstream accepts Out this cycle
- count  output  2  number of words held (0, 1 or 2)
- overflow  output  1  sticky flag: in_valid was asserted while in_ready was 0

## Operation
- Storage: head register (drives Out) and skid register; state register with states EMPTY, ONE, FULL.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready is decoded from state: 1 in EMPTY and ONE, 0 in FULL. It does not depend combinationally on out_ready.
- out_valid = (state != EMPTY). count: EMPTY=0, ONE=1, FULL=2.
- Transitions, evaluated on the rising edge when flush=0:
  - EMPTY + push -> ONE; head <= In.
  - ONE + push + no pop -> FULL; skid <= In.
  - ONE + pop + no push -> EMPTY.
  - ONE + push + pop -> ONE; head <= In.
  - FULL + pop -> ONE; head <= skid. A push cannot occur because in_ready=0.
  - Any other combination holds state and data.
- Ordering: words leave strictly in arrival order. There is no loss and no duplication.
- overflow sets on any rising edge where in_valid=1 and in_ready=0. It clears only on reset or flush. The offending word is dropped.
- flush=1 has priority over push and pop: state <= EMPTY and overflow <= 0. Data registers may keep stale values, but Out is forced to 0 whenever out_valid=0.
- Out is 0 whenever state = EMPTY, so a gate-level X never propagates downstream.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately): state EMPTY, head/skid 0, Out=0, out_valid=0, count=0, overflow=0, in_ready=1 (decoded).
- Reset release: the first rising edge with rst_n=1 may already capture a push.
- Latency: a word pushed at edge N appears on Out with out_valid=1 after edge N. Throughput is 1 word/cycle with out_ready held at 1.
- Stall: if out_ready=0 for 2+ cycles, the buffer fills. in_ready drops after the edge that makes state FULL, and rises again after the first pop edge.
- Reset asserted mid-transfer: held words are discarded immediately, with no wait for a clock edge. The word being pushed in that cycle is lost.
- In is sampled only on the rising edge. Because upstream launches on the negedge, the sampling margin is half a clock period; the block adds no further synchronization.

## Test plan
- Reset with in_valid=1, In=2'b11 -> Out=0, out_valid=0, count=0, in_ready=1 while rst_n=0. After release, the first edge captures 2'b11 and out_valid=1.
- Stream 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles with out_ready=1 -> Out shows the same sequence one cycle later, count stays 1, in_ready never drops.
- Push 2'b01 then 2'b10 with out_ready=0 -> count=2, in_ready=0. Then out_ready=1 -> Out=2'b01, then 2'b10, then out_valid=0.
- While FULL, assert in_valid with In=2'b11 -> overflow=1 and stays 1. 2'b11 is never output. A subsequent flush clears overflow and count to 0.
- In state ONE (head=2'b10), push 2'b01 and pop in the same edge -> count stays 1, Out=2'b01 next cycle.
- Drop rst_n mid-cycle while FULL -> out_valid, count and Out go to 0 before the next clock edge. in_ready=1.
